call_scheduler: RTL

CALL_SCHEDULER -- requirements
Module: call_scheduler

---
 rtl/call_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/call_scheduler.sv
// Elevator hall-call scheduler: latches call-button rising edges, picks the next
// target floor with a SCAN rule and supervises the trip with dwell and timeout counters.
module call_scheduler #(
   parameter int unsigned DWELL   = 8,
   parameter int unsigned TIMEOUT = 200
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] call_button,
   input  logic [1:0] current_floor,
   input  logic       car_idle,
   output logic [3:0] target_key,
   output logic [3:0] call_lamp,
   output logic       going_up,
   output logic       fault
);

   localparam int unsigned NF  = 4;
   localparam int unsigned FW  = 2;
   localparam int unsigned TCW = 8;
   localparam int unsigned DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

   typedef enum logic [1:0] {
      IDLE,
      TRAVEL,
      ARRIVED
   } state_t;

   state_t          state_q, state_d;
   logic [NF-1:0]   btn_q;
   logic [NF-1:0]   pending_q, pending_d;
   logic [FW-1:0]   target_q, target_d;
   logic [NF-1:0]   key_q, key_d;
   logic            up_q, up_d;
   logic            fault_q, fault_d;
   logic [TCW-1:0]  tcnt_q, tcnt_d;
   logic [DCW-1:0]  dcnt_q, dcnt_d;

   logic [NF-1:0]   rise;
   logic [NF-1:0]   clr;
   logic [NF-1:0]   above, below;
   logic [FW-1:0]   lo_above, hi_below, pick;
   logic            pick_up;

   assign rise = call_button & ~btn_q;

   // Pending calls split around the current floor, nearest candidate on each side
   always_comb begin
      above    = '0;
      below    = '0;
      lo_above = '0;
      hi_below = '0;
      for (int i = 0; i < int'(NF); i++) begin
         if (FW'(i) > current_floor) above[i] = pending_q[i];
         if (FW'(i) < current_floor) below[i] = pending_q[i];
      end
      for (int i = int'(NF) - 1; i >= 0; i--) begin
         if (above[i]) lo_above = FW'(i);
      end
      for (int i = 0; i < int'(NF); i++) begin
         if (below[i]) hi_below = FW'(i);
      end
   end

   // SCAN choice: keep direction if a call lies ahead, otherwise reverse
   always_comb begin
      pick    = '0;
      pick_up = up_q;
      if (up_q) begin
         if (|above) begin
            pick = lo_above;
         end else begin
            pick    = hi_below;
            pick_up = 1'b0;
         end
      end else begin
         if (|below) begin
            pick = hi_below;
         end else begin
            pick    = lo_above;
            pick_up = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      key_d    = key_q;
      up_d     = up_q;
      fault_d  = 1'b0;
      tcnt_d   = tcnt_q;
      dcnt_d   = dcnt_q;
      clr      = '0;
      case (state_q)
         IDLE: begin
            key_d = '0;
            if (car_idle) begin
               if (pending_q[current_floor]) begin
                  clr[current_floor] = 1'b1;
               end else if (|pending_q) begin
                  state_d  = TRAVEL;
                  target_d = pick;
                  up_d     = pick_up;
                  key_d    = NF'(1) << pick;
                  tcnt_d   = '0;
               end
            end
         end
         TRAVEL: begin
            if (current_floor == target_q) begin
               state_d       = ARRIVED;
               key_d         = '0;
               clr[target_q] = 1'b1;
               dcnt_d        = '0;
            end else if (tcnt_q == TCW'(TIMEOUT - 1)) begin
               state_d = IDLE;
               key_d   = '0;
               fault_d = 1'b1;
            end else begin
               tcnt_d = tcnt_q + TCW'(1);
            end
         end
         ARRIVED: begin
            key_d = '0;
            if (dcnt_q == DCW'(DWELL - 1)) begin
               state_d = IDLE;
            end else begin
               dcnt_d = dcnt_q + DCW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            key_d   = '0;
         end
      endcase
   end

   // Clearing a served floor overrides a coincident new press of that floor
   assign pending_d = (pending_q | rise) & ~clr;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         btn_q     <= '0;
         pending_q <= '0;
         target_q  <= '0;
         key_q     <= '0;
         up_q      <= 1'b1;
         fault_q   <= 1'b0;
         tcnt_q    <= '0;
         dcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         btn_q     <= call_button;
         pending_q <= pending_d;
         target_q  <= target_d;
         key_q     <= key_d;
         up_q      <= up_d;
         fault_q   <= fault_d;
         tcnt_q    <= tcnt_d;
         dcnt_q    <= dcnt_d;
      end
   end

   assign target_key = key_q;
   assign call_lamp  = pending_q;
   assign going_up   = up_q;
   assign fault      = fault_q;

endmodule
